// File: rtl/mux2_4_arbiter_if.sv
// Requester/arbiter bus for the shared 2:1 word mux: two request/data pairs in,
// grants, select and the registered output word with its valid flag out.
interface mux2_4_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gnt_a;
    logic             gnt_b;
    logic             s;
    logic [WIDTH-1:0] out;
    logic             valid;

    // Handshake: a requester raises req_x and holds it, with its word on a/b, for
    // as long as it wants the bus; gnt_x marks ownership, and out/valid carry the
    // owner's word one cycle later. There is no back-pressure on out.
    modport master (
        output req_a, req_b, a, b,
        input  gnt_a, gnt_b, s, out, valid
    );

    modport slave (
        input  req_a, req_b, a, b,
        output gnt_a, gnt_b, s, out, valid
    );
endinterface

// File: rtl/mux2_4_arbiter.sv
// Round-robin arbiter for two requesters sharing one registered 2:1 word mux,
// with bounded ownership under contention (MAX_HOLD cycles).
module mux2_4_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    mux2_4_arbiter_if.slave    bus,
    output logic [1:0]         state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             last_b;
    logic             gnt_a_r;
    logic             gnt_b_r;
    logic             s_r;
    logic [WIDTH-1:0] out_r;
    logic             valid_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            last_b  <= 1'b1;
            gnt_a_r <= 1'b0;
            gnt_b_r <= 1'b0;
            s_r     <= 1'b0;
            out_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_r <= 1'b0;
                    // On a tie, whoever was not served last wins.
                    if ((bus.req_a && bus.req_b && last_b) || (bus.req_a && !bus.req_b)) begin
                        state <= OWN_A; gnt_a_r <= 1'b1; gnt_b_r <= 1'b0;
                        s_r <= 1'b0; cnt <= '0; last_b <= 1'b0;
                    end else if (bus.req_b) begin
                        state <= OWN_B; gnt_a_r <= 1'b0; gnt_b_r <= 1'b1;
                        s_r <= 1'b1; cnt <= '0; last_b <= 1'b1;
                    end
                end
                OWN_A: begin
                    out_r   <= bus.a;
                    valid_r <= 1'b1;
                    if (bus.req_b && (!bus.req_a || cnt == CNT_MAX)) begin
                        state <= OWN_B; gnt_a_r <= 1'b0; gnt_b_r <= 1'b1;
                        s_r <= 1'b1; cnt <= '0; last_b <= 1'b1;
                    end else if (!bus.req_a) begin
                        state <= IDLE; gnt_a_r <= 1'b0; gnt_b_r <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OWN_B: begin
                    out_r   <= bus.b;
                    valid_r <= 1'b1;
                    if (bus.req_a && (!bus.req_b || cnt == CNT_MAX)) begin
                        state <= OWN_A; gnt_a_r <= 1'b1; gnt_b_r <= 1'b0;
                        s_r <= 1'b0; cnt <= '0; last_b <= 1'b0;
                    end else if (!bus.req_b) begin
                        state <= IDLE; gnt_a_r <= 1'b0; gnt_b_r <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_a_r <= 1'b0;
                    gnt_b_r <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_a = gnt_a_r;
    assign bus.gnt_b = gnt_b_r;
    assign bus.s     = s_r;
    assign bus.out   = out_r;
    assign bus.valid = valid_r;
    assign state_dbg = state;
endmodule

// File: tb/tb_mux2_4_arbiter.sv
// Bench for mux2_4_arbiter: MAX_HOLD=4 and MAX_HOLD=1 instances on shared stimulus,
// each checked against an owner/hold-count reference model every cycle.
module tb_mux2_4_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [3:0] a, b;
    logic [1:0] state_dbg0, state_dbg1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux2_4_arbiter_if #(.WIDTH(4)) bus0 ();
    mux2_4_arbiter_if #(.WIDTH(4)) bus1 ();

    assign bus0.req_a = req_a;  assign bus1.req_a = req_a;
    assign bus0.req_b = req_b;  assign bus1.req_b = req_b;
    assign bus0.a     = a;      assign bus1.a     = a;
    assign bus0.b     = b;      assign bus1.b     = b;

    mux2_4_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .state_dbg(state_dbg0));
    mux2_4_arbiter #(.WIDTH(4), .MAX_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .state_dbg(state_dbg1));

    // Reference model: owner 0=none, 1=A, 2=B; held = cycles owned beyond the first.
    int         hold_lim [2] = '{4, 1};
    int         m_owner  [2];
    int         m_held   [2];
    int         m_last   [2];
    logic       m_s      [2];
    logic       m_valid  [2];
    logic [3:0] m_out    [2];

    task automatic model_step(input logic rst, input logic ra, input logic rb,
                              input logic [3:0] da, input logic [3:0] db);
        for (int k = 0; k < 2; k++) begin
            int  nxt;
            int  other;
            logic mine, theirs;
            if (rst) begin
                m_owner[k] = 0; m_held[k] = 0; m_last[k] = 2;
                m_s[k] = 1'b0; m_valid[k] = 1'b0; m_out[k] = 4'd0;
            end else begin
                if (m_owner[k] == 1)      begin m_out[k] = da; m_valid[k] = 1'b1; end
                else if (m_owner[k] == 2) begin m_out[k] = db; m_valid[k] = 1'b1; end
                else                            m_valid[k] = 1'b0;
                if (m_owner[k] == 0) begin
                    if (ra && rb) nxt = (m_last[k] == 1) ? 2 : 1;
                    else if (ra)  nxt = 1;
                    else if (rb)  nxt = 2;
                    else          nxt = 0;
                end else begin
                    mine   = (m_owner[k] == 1) ? ra : rb;
                    theirs = (m_owner[k] == 1) ? rb : ra;
                    other  = 3 - m_owner[k];
                    if (!mine)                                    nxt = theirs ? other : 0;
                    else if (theirs && m_held[k] + 1 >= hold_lim[k]) nxt = other;
                    else                                          nxt = m_owner[k];
                end
                if (nxt != 0 && nxt != m_owner[k]) begin
                    m_held[k] = 0;
                    m_last[k] = nxt;
                end else if (nxt != 0) begin
                    m_held[k] = m_held[k] + 1;
                end
                if (nxt == 1) m_s[k] = 1'b0;
                if (nxt == 2) m_s[k] = 1'b1;
                m_owner[k] = nxt;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("h4_gnt_a", 32'(bus0.gnt_a), 32'(m_owner[0] == 1));
        chk("h4_gnt_b", 32'(bus0.gnt_b), 32'(m_owner[0] == 2));
        chk("h4_s",     32'(bus0.s),     32'(m_s[0]));
        chk("h4_valid", 32'(bus0.valid), 32'(m_valid[0]));
        chk("h4_out",   32'(bus0.out),   32'(m_out[0]));
        chk("h1_gnt_a", 32'(bus1.gnt_a), 32'(m_owner[1] == 1));
        chk("h1_gnt_b", 32'(bus1.gnt_b), 32'(m_owner[1] == 2));
        chk("h1_s",     32'(bus1.s),     32'(m_s[1]));
        chk("h1_valid", 32'(bus1.valid), 32'(m_valid[1]));
        chk("h1_out",   32'(bus1.out),   32'(m_out[1]));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare #1 after it.
    task automatic step(input logic rst, input logic ra, input logic rb,
                        input logic [3:0] da, input logic [3:0] db);
        reset = rst; req_a = ra; req_b = rb; a = da; b = db;
        @(posedge clk);
        model_step(rst, ra, rb, da, db);
        #1;
        check_all();
    endtask

    initial begin
        logic ra, rb;
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; a = 4'd0; b = 4'd0;

        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("idle_out_lit", 32'(bus0.out), 32'h0);

        // A alone, then release.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 4'b0001, 4'd0);
        chk("a_alone_out_lit", 32'(bus0.out), 32'h1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 4'b0001, 4'd0);

        // Sustained contention: 4/4 alternation on dut0, every-cycle on dut1.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0010);
        for (int i = 0; i < 2; i++)  step(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0010);

        // A owns, drops while B waits: direct handover.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 4'b0101, 4'b0010);
        step(1'b0, 1'b0, 1'b1, 4'b0101, 4'b0010);
        chk("handover_gnt_b_lit", 32'(bus0.gnt_b), 32'h1);
        step(1'b0, 1'b0, 1'b1, 4'b0101, 4'b0010);
        chk("handover_out_lit", 32'(bus0.out), 32'h2);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        // B alone for 10 cycles: no preemption without contention.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 4'd0, 4'b0011);
        chk("b_alone_gnt_lit", 32'(bus0.gnt_b), 32'h1);
        chk("b_alone_out_lit", 32'(bus0.out), 32'h3);

        // Reset mid-transfer, then a tie goes to A.
        step(1'b1, 1'b0, 1'b1, 4'd0, 4'b0011);
        chk("midreset_gnt_b_lit", 32'(bus0.gnt_b), 32'h0);
        chk("midreset_valid_lit", 32'(bus0.valid), 32'h0);
        step(1'b0, 1'b1, 1'b1, 4'b1001, 4'b0110);
        chk("tie_after_reset_lit", 32'(bus0.gnt_a), 32'h1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'b1001, 4'b0110);

        // Random phase: sticky requests, streaming data, rare resets.
        ra = 1'b0; rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            step(($urandom_range(0, 60) == 0), ra, rb,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            chk("never_both", 32'(bus0.gnt_a & bus0.gnt_b | bus1.gnt_a & bus1.gnt_b), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
